speed_mode_ctrl: RTL and testbench



---
 rtl/speed_mode_pkg.sv | 19 +
 rtl/jp_debounce.sv | 44 ++++
 rtl/speed_mode_ctrl.sv | 109 ++++++++++
 tb/tb_speed_mode_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/speed_mode_pkg.sv
// speed_mode_pkg: FSM encoding and elaboration-time helpers shared by the
// speed-mode controller files.
package speed_mode_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_RUN    = 2'd0;
  localparam state_t S_WAIT   = 2'd1;
  localparam state_t S_COMMIT = 2'd2;

  // Smallest width w with 2^w >= value; used to size and check counters.
  function automatic int clog2_f(input int unsigned value);
    int bits;
    bits = 0;
    while (bits < 31 && (32'd1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/jp_debounce.sv
// jp_debounce: one jumper bit -> synchroniser chain -> debounce counter.
// A level is accepted only after the synchronised input has differed from
// the accepted level for DEBOUNCE_LIMIT consecutive cycles.
module jp_debounce #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_LIMIT = 2000000,
  parameter int CNT_W          = 21
) (
  input  logic C100M,
  input  logic RESET_n,
  input  logic jp_raw,
  output logic jp_stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   js;

  assign js = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; reset preloads the raw level so nothing starts debouncing after reset.
  always_ff @(posedge C100M) begin
    if (!RESET_n) sync_q <= {SYNC_STAGES{jp_raw}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], jp_raw};
  end

  // Count consecutive disagreement cycles; any glitch back to the accepted level restarts the count.
  always_ff @(posedge C100M) begin
    if (!RESET_n) begin
      jp_stable <= jp_raw;
      cnt       <= '0;
    end else if (js == jp_stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      jp_stable <= js;
      cnt       <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/speed_mode_ctrl.sv
// speed_mode_ctrl: debounces the jumper vector and commits a new CPU speed
// mode only once the 68k bus has been idle long enough and LOCK is low.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | MODE matches the debounced jumpers, nothing to do
// S_WAIT   | debounced mode differs; waiting for idle bus and !LOCK
// S_COMMIT | load MODE from debounced jumpers, pulse MODE_CHANGE
module speed_mode_ctrl
  import speed_mode_pkg::*;
#(
  parameter int NUM_JP         = 4,
  parameter int MODE_BITS      = 1,
  parameter int DEBOUNCE_LIMIT = 2000000,
  parameter int CNT_W          = 21,
  parameter int SYNC_STAGES    = 2,
  parameter int IDLE_CYCLES    = 2
) (
  input  logic                 C100M,
  input  logic                 RESET_n,
  input  logic [NUM_JP-1:0]    JP_IN,
  input  logic                 AS_CPU_n,
  input  logic                 DTACK_CPU_n,
  input  logic                 LOCK,
  output logic [NUM_JP-1:0]    JP_STABLE,
  output logic [MODE_BITS-1:0] MODE,
  output logic                 MODE_CHANGE,
  output logic                 PENDING
);

  localparam int IDLE_W_RAW = clog2_f(IDLE_CYCLES + 1);
  localparam int IDLE_W     = (IDLE_W_RAW < 1) ? 1 : IDLE_W_RAW;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

  if (CNT_W < clog2_f(DEBOUNCE_LIMIT + 1) || DEBOUNCE_LIMIT < 2) begin : g_bad_debounce
    $error("speed_mode_ctrl: CNT_W cannot hold DEBOUNCE_LIMIT, or DEBOUNCE_LIMIT < 2");
  end
  if (MODE_BITS < 1 || MODE_BITS > NUM_JP || SYNC_STAGES < 2 || IDLE_CYCLES < 1) begin : g_bad_shape
    $error("speed_mode_ctrl: MODE_BITS, SYNC_STAGES or IDLE_CYCLES out of range");
  end

  logic [SYNC_STAGES-1:0] as_q;
  logic [SYNC_STAGES-1:0] dtack_q;
  logic                   bus_idle_s;
  logic [IDLE_W-1:0]      idle_cnt;
  logic [MODE_BITS-1:0]   mode_next;
  state_t                 state;

  for (genvar gi = 0; gi < NUM_JP; gi++) begin : g_jp
    jp_debounce #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
      .CNT_W         (CNT_W)
    ) u_jp_debounce (
      .C100M    (C100M),
      .RESET_n  (RESET_n),
      .jp_raw   (JP_IN[gi]),
      .jp_stable(JP_STABLE[gi])
    );
  end

  // Bus strobe synchronisers, same flop-chain style as the jumper bits.
  always_ff @(posedge C100M) begin
    if (!RESET_n) begin
      as_q    <= {SYNC_STAGES{AS_CPU_n}};
      dtack_q <= {SYNC_STAGES{DTACK_CPU_n}};
    end else begin
      as_q    <= {as_q[SYNC_STAGES-2:0], AS_CPU_n};
      dtack_q <= {dtack_q[SYNC_STAGES-2:0], DTACK_CPU_n};
    end
  end

  assign bus_idle_s = as_q[SYNC_STAGES-1] & dtack_q[SYNC_STAGES-1];
  assign mode_next  = JP_STABLE[MODE_BITS-1:0];
  assign PENDING    = (mode_next != MODE);

  // Count consecutive idle-bus cycles, saturating at IDLE_CYCLES.
  always_ff @(posedge C100M) begin
    if (!RESET_n || !bus_idle_s) idle_cnt <= '0;
    else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  // Mode-commit FSM; the commit decision is taken in S_WAIT, so a bus going busy during S_COMMIT does not abort it.
  always_ff @(posedge C100M) begin
    if (!RESET_n) begin
      state       <= S_RUN;
      MODE        <= JP_IN[MODE_BITS-1:0];
      MODE_CHANGE <= 1'b0;
    end else begin
      MODE_CHANGE <= 1'b0;
      case (state)
        S_RUN: begin
          if (PENDING) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!PENDING) state <= S_RUN;
          else if (idle_cnt == IDLE_MAX && !LOCK) state <= S_COMMIT;
        end
        S_COMMIT: begin
          MODE        <= mode_next;
          MODE_CHANGE <= 1'b1;
          state       <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_speed_mode_ctrl.sv
// tb_speed_mode_ctrl: directed scenarios; every MODE_CHANGE pulse is matched
// against a queue of hand-computed (mode, cycle) commits.
module tb_speed_mode_ctrl;

  logic       clk = 1'b0;
  logic       RESET_n;
  logic [3:0] JP_IN;
  logic       AS_CPU_n;
  logic       DTACK_CPU_n;
  logic       LOCK;
  logic [3:0] JP_STABLE;
  logic [0:0] MODE;
  logic       MODE_CHANGE;
  logic       PENDING;

  typedef struct {
    int mode;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   c0;

  speed_mode_ctrl #(
    .NUM_JP        (4),
    .MODE_BITS     (1),
    .DEBOUNCE_LIMIT(8),
    .CNT_W         (4),
    .SYNC_STAGES   (2),
    .IDLE_CYCLES   (2)
  ) dut (
    .C100M      (clk),
    .RESET_n    (RESET_n),
    .JP_IN      (JP_IN),
    .AS_CPU_n   (AS_CPU_n),
    .DTACK_CPU_n(DTACK_CPU_n),
    .LOCK       (LOCK),
    .JP_STABLE  (JP_STABLE),
    .MODE       (MODE),
    .MODE_CHANGE(MODE_CHANGE),
    .PENDING    (PENDING)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_commit(input int m, input int at);
    exp_t e;
    e.mode = m;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Monitor: each MODE_CHANGE pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (MODE_CHANGE === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_mode_change", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_mode", int'(MODE), e.mode);
        chk("commit_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET_n     = 1'b0;
    JP_IN       = 4'b1010;
    AS_CPU_n    = 1'b1;
    DTACK_CPU_n = 1'b1;
    LOCK        = 1'b0;
    tick(2);
    RESET_n = 1'b1;

    // 1: reset state
    tick(1);
    chk("rst_jp_stable", JP_STABLE, 4'b1010);
    chk("rst_mode", MODE, 0);
    chk("rst_pending", PENDING, 0);
    chk("rst_mode_change", MODE_CHANGE, 0);
    tick(4);

    // 2: debounce + commit latency on an idle bus
    c0 = cyc;
    JP_IN = 4'b1011;
    push_commit(1, c0 + 13);
    tick(9);
    chk("t2_stable_early", JP_STABLE, 4'b1010);
    chk("t2_pending_early", PENDING, 0);
    tick(1);
    chk("t2_stable", JP_STABLE, 4'b1011);
    chk("t2_pending", PENDING, 1);
    tick(2);
    chk("t2_mode_before", MODE, 0);
    chk("t2_pending_hold", PENDING, 1);
    tick(1);
    chk("t2_mode_after", MODE, 1);
    chk("t2_pending_clr", PENDING, 0);
    chk("t2_pulse", MODE_CHANGE, 1);
    tick(1);
    chk("t2_pulse_end", MODE_CHANGE, 0);

    // 3: glitches one cycle short of the limit are rejected
    for (int r = 0; r < 5; r++) begin
      JP_IN[0] = 1'b0;
      tick(7);
      JP_IN[0] = 1'b1;
      tick(4);
      chk("t3_stable", JP_STABLE, 4'b1011);
      chk("t3_pending", PENDING, 0);
    end
    chk("t3_mode", MODE, 1);

    // 4: busy bus blocks the commit; both strobes must be high
    AS_CPU_n = 1'b0;
    tick(3);
    JP_IN = 4'b1010;
    tick(10);
    chk("t4_stable", JP_STABLE, 4'b1010);
    chk("t4_pending", PENDING, 1);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("t4_as_busy_mode", MODE, 1);
    end
    chk("t4_pending_hold", PENDING, 1);
    AS_CPU_n    = 1'b1;
    DTACK_CPU_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t4_dtack_busy_mode", MODE, 1);
    end
    c0 = cyc;
    DTACK_CPU_n = 1'b1;
    push_commit(0, c0 + 6);
    tick(5);
    chk("t4_mode_before", MODE, 1);
    tick(1);
    chk("t4_mode_after", MODE, 0);
    chk("t4_pulse", MODE_CHANGE, 1);
    chk("t4_pending_clr", PENDING, 0);

    // 5: LOCK holds S_WAIT
    LOCK  = 1'b1;
    JP_IN = 4'b1011;
    tick(10);
    chk("t5_stable", JP_STABLE, 4'b1011);
    chk("t5_pending", PENDING, 1);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk("t5_locked_mode", MODE, 0);
    end
    c0 = cyc;
    LOCK = 1'b0;
    push_commit(1, c0 + 2);
    tick(1);
    chk("t5_mode_commit_cycle", MODE, 0);
    tick(1);
    chk("t5_mode_after", MODE, 1);
    chk("t5_pulse", MODE_CHANGE, 1);

    // 6: reset while waiting reloads MODE from JP_IN with no pulse
    c0 = cyc;
    JP_IN = 4'b1010;
    push_commit(0, c0 + 13);
    tick(14);
    chk("t6_mode_pre", MODE, 0);
    LOCK  = 1'b1;
    JP_IN = 4'b1011;
    tick(11);
    chk("t6_pending_wait", PENDING, 1);
    chk("t6_mode_wait", MODE, 0);
    RESET_n = 1'b0;
    tick(1);
    RESET_n = 1'b1;
    chk("t6_mode_rst", MODE, 1);
    chk("t6_pending_rst", PENDING, 0);
    chk("t6_pulse_rst", MODE_CHANGE, 0);
    chk("t6_stable_rst", JP_STABLE, 4'b1011);
    LOCK = 1'b0;
    tick(20);
    chk("t6_mode_final", MODE, 1);
    chk("t6_pending_final", PENDING, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
